// File: rtl/instruction_fetch_stage.sv
// Fetch stage: owns the PC, drives instruction-memory address and fills the IF/ID register.
// Handles redirects, stalls and halt-word detection via an IDLE/RUN/HALT FSM.
module instruction_fetch_stage #(
    parameter int                 PC_WIDTH    = 32,
    parameter int                 INSTR_WIDTH = 32,
    parameter logic [PC_WIDTH-1:0]    RESET_PC  = 32'h0000_0000,
    parameter logic [INSTR_WIDTH-1:0] HALT_WORD = 32'hFFFF_FFFF,
    parameter int                 COUNT_WIDTH = 16
) (
    input  logic                   Clk,
    input  logic                   Reset,
    output logic [PC_WIDTH-1:0]    Imem_Addr,
    input  logic [INSTR_WIDTH-1:0] Imem_Data,
    input  logic                   Stall,
    input  logic                   Redirect,
    input  logic [PC_WIDTH-1:0]    Redirect_Target,
    output logic [INSTR_WIDTH-1:0] IF_ID_Instr,
    output logic [PC_WIDTH-1:0]    IF_ID_PC4,
    output logic                   IF_ID_Valid,
    output logic                   Halted,
    output logic [COUNT_WIDTH-1:0] Fetch_Count
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic [PC_WIDTH-1:0]    pc_q, pc_d;
    logic [INSTR_WIDTH-1:0] instr_q, instr_d;
    logic [PC_WIDTH-1:0]    pc4_q, pc4_d;
    logic                   valid_q, valid_d;
    logic                   halted_q, halted_d;
    logic [COUNT_WIDTH-1:0] count_q, count_d;
    logic [PC_WIDTH-1:0]    pc_plus4_s;

    assign pc_plus4_s = pc_q + PC_WIDTH'(4);

    // Next-state and IF/ID update; in RUN the priority is redirect, stall, halt, fetch.
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        instr_d  = instr_q;
        pc4_d    = pc4_q;
        valid_d  = valid_q;
        halted_d = halted_q;
        count_d  = count_q;
        case (state_q)
            ST_IDLE: begin
                state_d = ST_RUN;
            end
            ST_RUN: begin
                if (Redirect) begin
                    pc_d    = {Redirect_Target[PC_WIDTH-1:2], 2'b00};
                    instr_d = '0;
                    pc4_d   = '0;
                    valid_d = 1'b0;
                end else if (Stall) begin
                    pc_d = pc_q;
                end else if (Imem_Data == HALT_WORD) begin
                    // The halt word itself is never delivered or counted.
                    state_d  = ST_HALT;
                    halted_d = 1'b1;
                    valid_d  = 1'b0;
                end else begin
                    pc_d    = pc_plus4_s;
                    instr_d = Imem_Data;
                    pc4_d   = pc_plus4_s;
                    valid_d = 1'b1;
                    if (count_q != {COUNT_WIDTH{1'b1}}) begin
                        count_d = count_q + COUNT_WIDTH'(1);
                    end else begin
                        count_d = count_q;
                    end
                end
            end
            ST_HALT: begin
                valid_d  = 1'b0;
                halted_d = 1'b1;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, PC and IF/ID registers.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q  <= ST_IDLE;
            pc_q     <= RESET_PC;
            instr_q  <= '0;
            pc4_q    <= '0;
            valid_q  <= 1'b0;
            halted_q <= 1'b0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            instr_q  <= instr_d;
            pc4_q    <= pc4_d;
            valid_q  <= valid_d;
            halted_q <= halted_d;
            count_q  <= count_d;
        end
    end

    assign Imem_Addr   = pc_q;
    assign IF_ID_Instr = instr_q;
    assign IF_ID_PC4   = pc4_q;
    assign IF_ID_Valid = valid_q;
    assign Halted      = halted_q;
    assign Fetch_Count = count_q;

endmodule

// File: tb/tb_instruction_fetch_stage.sv
// Self-checking bench for instruction_fetch_stage: vector table plus directed
// halt, reset-during-run and PC wrap sequences.
module tb_instruction_fetch_stage;

    logic        Clk;
    logic        Reset;
    logic [31:0] Imem_Addr;
    logic [31:0] Imem_Data;
    logic        Stall;
    logic        Redirect;
    logic [31:0] Redirect_Target;
    logic [31:0] IF_ID_Instr;
    logic [31:0] IF_ID_PC4;
    logic        IF_ID_Valid;
    logic        Halted;
    logic [15:0] Fetch_Count;

    logic        halt_en;
    int          checks;
    int          errors;

    instruction_fetch_stage dut (
        .Clk             (Clk),
        .Reset           (Reset),
        .Imem_Addr       (Imem_Addr),
        .Imem_Data       (Imem_Data),
        .Stall           (Stall),
        .Redirect        (Redirect),
        .Redirect_Target (Redirect_Target),
        .IF_ID_Instr     (IF_ID_Instr),
        .IF_ID_PC4       (IF_ID_PC4),
        .IF_ID_Valid     (IF_ID_Valid),
        .Halted          (Halted),
        .Fetch_Count     (Fetch_Count)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Memory model: word[i] = 0x1000_0000 + i, word[5] optionally the halt word.
    always_comb begin
        if (halt_en && (Imem_Addr == 32'h0000_0014)) begin
            Imem_Data = 32'hFFFF_FFFF;
        end else begin
            Imem_Data = 32'h1000_0000 + {2'b00, Imem_Addr[31:2]};
        end
    end

    typedef struct {
        logic        stall;
        logic        redirect;
        logic [31:0] target;
        logic [31:0] e_addr;
        logic [31:0] e_instr;
        logic [31:0] e_pc4;
        logic        e_valid;
        logic        e_halted;
        logic [15:0] e_count;
    } vec_t;

    vec_t vecs [8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_all(input string tag, input logic [31:0] addr, input logic [31:0] instr,
                             input logic [31:0] pc4, input logic valid, input logic halted,
                             input logic [15:0] count);
        check({tag, ".addr"},   Imem_Addr,           addr);
        check({tag, ".instr"},  IF_ID_Instr,         instr);
        check({tag, ".pc4"},    IF_ID_PC4,           pc4);
        check({tag, ".valid"},  {31'd0, IF_ID_Valid}, {31'd0, valid});
        check({tag, ".halted"}, {31'd0, Halted},     {31'd0, halted});
        check({tag, ".count"},  {16'd0, Fetch_Count}, {16'd0, count});
    endtask

    task automatic step(input logic st, input logic rd, input logic [31:0] tgt);
        Stall           = st;
        Redirect        = rd;
        Redirect_Target = tgt;
        @(posedge Clk);
        @(negedge Clk);
        Stall    = 1'b0;
        Redirect = 1'b0;
    endtask

    // Called at a negedge: pulse reset mid-cycle and check values before any edge.
    task automatic reset_pulse(input string tag);
        Reset = 1'b0;
        #1;
        check_all(tag, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 16'd0);
        #1;
        Reset = 1'b1;
    endtask

    initial begin
        checks          = 0;
        errors          = 0;
        halt_en         = 1'b0;
        Stall           = 1'b0;
        Redirect        = 1'b0;
        Redirect_Target = 32'h0;

        //           st    rd    target        addr          instr         pc4           v     h     cnt
        vecs[0] = '{1'b0, 1'b1, 32'h0000_0040, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 1'b0, 1'b0, 16'd0};
        vecs[1] = '{1'b0, 1'b0, 32'h0000_0000, 32'h0000_0004, 32'h1000_0000, 32'h0000_0004, 1'b1, 1'b0, 16'd1};
        vecs[2] = '{1'b0, 1'b0, 32'h0000_0000, 32'h0000_0008, 32'h1000_0001, 32'h0000_0008, 1'b1, 1'b0, 16'd2};
        vecs[3] = '{1'b1, 1'b0, 32'h0000_0000, 32'h0000_0008, 32'h1000_0001, 32'h0000_0008, 1'b1, 1'b0, 16'd2};
        vecs[4] = '{1'b1, 1'b0, 32'h0000_0000, 32'h0000_0008, 32'h1000_0001, 32'h0000_0008, 1'b1, 1'b0, 16'd2};
        vecs[5] = '{1'b0, 1'b0, 32'h0000_0000, 32'h0000_000C, 32'h1000_0002, 32'h0000_000C, 1'b1, 1'b0, 16'd3};
        vecs[6] = '{1'b1, 1'b1, 32'h0000_0022, 32'h0000_0020, 32'h0000_0000, 32'h0000_0000, 1'b0, 1'b0, 16'd3};
        vecs[7] = '{1'b0, 1'b0, 32'h0000_0000, 32'h0000_0024, 32'h1000_0008, 32'h0000_0024, 1'b1, 1'b0, 16'd4};

        Reset = 1'b0;
        #1;
        check_all("reset", 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 16'd0);
        #1;
        Reset = 1'b1;

        for (int i = 0; i < 8; i++) begin
            step(vecs[i].stall, vecs[i].redirect, vecs[i].target);
            check_all($sformatf("vec%0d", i), vecs[i].e_addr, vecs[i].e_instr, vecs[i].e_pc4,
                      vecs[i].e_valid, vecs[i].e_halted, vecs[i].e_count);
        end

        // Halt scenario: linear run into word[5] = halt word.
        halt_en = 1'b1;
        reset_pulse("rst_pre_halt");
        step(1'b0, 1'b0, 32'h0);
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 1'b0, 32'h0);
        end
        check_all("pre_halt", 32'h14, 32'h1000_0004, 32'h14, 1'b1, 1'b0, 16'd5);
        step(1'b1, 1'b0, 32'h0);
        check_all("stall_no_halt", 32'h14, 32'h1000_0004, 32'h14, 1'b1, 1'b0, 16'd5);
        step(1'b0, 1'b0, 32'h0);
        check_all("halt", 32'h14, 32'h1000_0004, 32'h14, 1'b0, 1'b1, 16'd5);
        step(1'b1, 1'b1, 32'h0);
        check_all("halt_redir_ign", 32'h14, 32'h1000_0004, 32'h14, 1'b0, 1'b1, 16'd5);
        step(1'b0, 1'b0, 32'h0);
        check_all("halt_hold", 32'h14, 32'h1000_0004, 32'h14, 1'b0, 1'b1, 16'd5);

        // Reset from HALT, then run to PC=0x10 and reset mid-stream.
        reset_pulse("rst_in_halt");
        halt_en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 1'b0, 32'h0);
        end
        check_all("pre_midrst", 32'h10, 32'h1000_0003, 32'h10, 1'b1, 1'b0, 16'd4);
        reset_pulse("rst_mid");
        step(1'b0, 1'b0, 32'h0);
        check_all("restart_idle", 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 16'd0);
        step(1'b0, 1'b0, 32'h0);
        check_all("restart_f1", 32'h4, 32'h1000_0000, 32'h4, 1'b1, 1'b0, 16'd1);
        step(1'b0, 1'b0, 32'h0);
        check_all("restart_f2", 32'h8, 32'h1000_0001, 32'h8, 1'b1, 1'b0, 16'd2);

        // PC wrap: unaligned target is forced to 0xFFFF_FFFC, next fetch wraps to 0.
        step(1'b0, 1'b1, 32'hFFFF_FFFF);
        check_all("wrap_redir", 32'hFFFF_FFFC, 32'h0, 32'h0, 1'b0, 1'b0, 16'd2);
        step(1'b0, 1'b0, 32'h0);
        check_all("wrap_fetch", 32'h0, 32'h4FFF_FFFF, 32'h0, 1'b1, 1'b0, 16'd3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/instruction_fetch_stage.md
Name: instruction_fetch_stage

Overview:
- Front-end fetch stage of the processor: owns the PC and drives the instruction-memory address.
- Applies branch/jump redirects and load-use stalls from downstream.
- Registers each fetched word, with its PC+4, into the IF/ID register consumed by the decode stage.
- Detects a halt word, freezes fetch and flags completion so a bench can end simulation cleanly.

Parameters:
- PC_WIDTH, 32, width of PC, target and address buses.
- INSTR_WIDTH, 32, instruction word width.
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- HALT_WORD, 32'hFFFF_FFFF, instruction encoding that stops fetch.
- COUNT_WIDTH, 16, width of fetch counter.

Ports:
- Clk  in  1  single clock, all state updates on rising edge.
- Reset  in  1  asynchronous, active-low reset (0 = reset).
- Imem_Addr  out  PC_WIDTH  byte address to instruction memory; always equals PC.
- Imem_Data  in  INSTR_WIDTH  instruction word; combinational read, valid in the same cycle as Imem_Addr.
- Stall  in  1  hold PC and IF/ID (hazard unit).
- Redirect  in  1  taken branch or jump this cycle.
- Redirect_Target  in  PC_WIDTH  new PC when Redirect=1.
- IF_ID_Instr  out  INSTR_WIDTH  registered instruction to decode.
- IF_ID_PC4  out  PC_WIDTH  registered PC+4 of that instruction.
- IF_ID_Valid  out  1  IF/ID holds a real instruction (0 = bubble).
- Halted  out  1  fetch stopped on HALT_WORD.
- Fetch_Count  out  COUNT_WIDTH  number of instructions delivered to IF/ID.

Behaviour:
- Reset low, asynchronous, dominates everything:
  - PC=RESET_PC; IF_ID_Instr=0, IF_ID_PC4=0, IF_ID_Valid=0; Halted=0; Fetch_Count=0; state=IDLE.
  - Reset asserted mid-operation, including in HALT, returns to exactly these values immediately, without waiting for a clock edge.
- FSM states IDLE, RUN, HALT:
  - IDLE: first rising edge after reset release goes to RUN. No PC change, IF_ID_Valid stays 0, inputs ignored. This guarantees a one-cycle settle.
  - RUN: per edge, priority Redirect > Stall > halt detect > normal fetch.
  - HALT: PC, IF/ID and counter frozen; IF_ID_Valid=0; Halted=1; Stall and Redirect ignored; exit only via reset.
- RUN, Redirect=1:
  - PC <= {Redirect_Target[PC_WIDTH-1:2],2'b00}; low two bits are forced to zero.
  - IF_ID_Valid <= 0 (squash wrong-path word); IF_ID_Instr and IF_ID_PC4 <= 0.
  - Counter unchanged.
  - Redirect overrides a simultaneous Stall.
  - Halt detection is suppressed that cycle, since the word on Imem_Data is wrong-path.
- RUN, Stall=1, Redirect=0: PC and all IF/ID outputs hold their values; counter unchanged; no halt detection.
- RUN, Imem_Data==HALT_WORD, no Stall or Redirect: next state HALT; Halted <= 1; PC holds; IF_ID_Valid <= 0. The halt word is never passed to decode and is not counted.
- RUN, normal fetch:
  - PC <= PC+4, modulo 2^PC_WIDTH (all-ones-minus-3 wraps to 0).
  - IF_ID_Instr <= Imem_Data; IF_ID_PC4 <= PC+4 (same wrap); IF_ID_Valid <= 1.
  - Fetch_Count <= Fetch_Count+1, saturating at all-ones.
- Latency: the word at address A appears on IF_ID_Instr one edge after PC==A. A redirect costs exactly one bubble.
- Imem_Addr is combinational from the PC register only; it has no path from Stall or Redirect.

Test Plan:
- Reset low 2 ns, high; memory word[i]=0x1000_0000+i.
  - Expect Imem_Addr=0 and Valid=0 after the 1st edge (IDLE→RUN).
  - Then IF_ID_Instr=0x1000_0000 with PC4=4, then 0x1000_0001 with PC4=8; Fetch_Count=1,2.
- Stall=1 for 2 cycles when PC=0x8: PC stays 0x8 and IF/ID holds 0x1000_0001 for both; after release the next IF_ID_Instr=0x1000_0002.
- Redirect=1, Target=0x22, Stall=1 simultaneously at PC=0xC:
  - Next cycle PC=0x20, Valid=0.
  - Following edge IF_ID_Instr=0x1000_0008, PC4=0x24; count advances by 1 only.
- word[5]=HALT_WORD, linear run:
  - At PC=0x14: Halted=1 next edge, PC stays 0x14, Valid=0, Fetch_Count=5.
  - A later Redirect to 0 is ignored.
- Reset pulsed low mid-stream at PC=0x10: all outputs zero and PC=RESET_PC before the next edge; restart repeats the first scenario.
- Force PC to 0xFFFF_FFFC via Redirect: next fetch PC4=0 and PC wraps to 0x0.
